eth_tx_arbiter: RTL and testbench



---
 rtl/eth_arb_pkg.sv | 18 +
 rtl/eth_rr_pick.sv | 37 +++
 rtl/eth_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
// Imported by eth_rr_pick and eth_tx_arbiter.
package eth_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_IFG   = 2'd2
   } arb_state_t;

   localparam int ETH_ARB_DEFAULT_IFG = 12;
   localparam int MAX_PORTS           = 8;

   function automatic int wrap_idx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational winner selection: optional strict priority for port 0,
// round-robin over the rest starting one past the last winner.
module eth_rr_pick
   import eth_arb_pkg::*;
#(
   parameter  int NUM_PORTS  = 4,
   parameter  int PRIO_PORT0 = 1,
   localparam int PTR_W      = $clog2(NUM_PORTS)
)(
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [PTR_W-1:0]     i_ptr,
   output logic [PTR_W-1:0]     o_idx,
   output logic                 o_valid
);

   logic [PTR_W-1:0] w_cand;

   // First requester at or after ptr+1; port 0 skipped when it has its own priority slot.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      if ((PRIO_PORT0 != 0) && i_req[0]) begin
         o_idx   = '0;
         o_valid = 1'b1;
      end else begin
         for (int off = 1; off <= NUM_PORTS; off++) begin
            w_cand = PTR_W'(wrap_idx(int'(i_ptr), off, NUM_PORTS));
            if (!o_valid && i_req[w_cand] && !((PRIO_PORT0 != 0) && (w_cand == '0))) begin
               o_idx   = w_cand;
               o_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// N-port arbiter and registered byte mux for the shared GMII TX path.
// Define ETH_ARB_TIMEOUT_EN to add the grant watchdog and timeout_err pulse.
module eth_tx_arbiter
   import eth_arb_pkg::*;
#(
   parameter  int NUM_PORTS      = 4,
   parameter  int IFG_CYCLES     = ETH_ARB_DEFAULT_IFG,
   parameter  int PRIO_PORT0     = 1,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int ID_W           = $clog2(NUM_PORTS)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PORTS-1:0]   port_req,
   input  logic [NUM_PORTS-1:0]   port_done,
   output logic [NUM_PORTS-1:0]   port_sel,
   input  logic [NUM_PORTS-1:0]   port_tx_en,
   input  logic [8*NUM_PORTS-1:0] port_txd,
   output logic                   gmii_tx_en,
   output logic [7:0]             gmii_txd,
   output logic [ID_W-1:0]        grant_id,
   output logic                   busy,
   output logic                   timeout_err
);

   if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS || IFG_CYCLES < 1 || IFG_CYCLES > 255 ||
       TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("eth_tx_arbiter: parameter out of range");
   end

   arb_state_t             r_state;
   arb_state_t             w_state_nxt;
   logic [NUM_PORTS-1:0]   r_port_sel;
   logic [NUM_PORTS-1:0]   w_sel_nxt;
   logic [ID_W-1:0]        r_grant_id;
   logic [ID_W-1:0]        r_rr_ptr;
   logic [ID_W-1:0]        w_pick_idx;
   logic                   w_pick_valid;
   logic [7:0]             r_ifg_cnt;
   logic                   r_mux_valid;
   logic                   r_gmii_tx_en;
   logic [7:0]             r_gmii_txd;
   logic                   r_busy;
   logic                   r_timeout_err;
   logic                   w_owner_done;
   logic                   w_timeout;
   logic                   w_grant;
   logic                   w_release;

   eth_rr_pick #(
      .NUM_PORTS  (NUM_PORTS),
      .PRIO_PORT0 (PRIO_PORT0)
   ) u_pick (
      .i_req   (port_req),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   assign w_owner_done = port_done[r_grant_id];

`ifdef ETH_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0] r_to_cnt;

   // Grant watchdog: zero outside GRANT, so every new grant starts from 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (r_state != ST_GRANT || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
      end
   end

   // A done arriving in the limit cycle wins over the watchdog.
   assign w_timeout = (r_state == ST_GRANT) && !w_owner_done &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; arbitration only happens from IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_state_nxt = ST_GRANT;
               w_grant     = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (w_owner_done || w_timeout) begin
               w_state_nxt = ST_IFG;
               w_release   = 1'b1;
            end else begin
               w_state_nxt = ST_GRANT;
            end
         end
         ST_IFG: begin
            if (r_ifg_cnt == 8'd0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_IFG;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // One-hot grant vector for the current winner.
   always_comb begin
      w_sel_nxt             = '0;
      w_sel_nxt[w_pick_idx] = 1'b1;
   end

   // Grant bookkeeping, gap counter and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_port_sel    <= '0;
         r_grant_id    <= '0;
         r_rr_ptr      <= ID_W'(NUM_PORTS - 1);
         r_ifg_cnt     <= 8'd0;
         r_mux_valid   <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_grant) begin
            r_port_sel <= w_sel_nxt;
            r_grant_id <= w_pick_idx;
            r_rr_ptr   <= w_pick_idx;
         end else if (w_release) begin
            r_port_sel <= '0;
         end
         if (w_release) begin
            r_ifg_cnt <= 8'(IFG_CYCLES - 1);
         end else if (r_state == ST_IFG && r_ifg_cnt != 8'd0) begin
            r_ifg_cnt <= r_ifg_cnt - 8'd1;
         end
         // Mux stays open through IFG so the owner's tail still reaches the PHY.
         r_mux_valid   <= (w_state_nxt != ST_IDLE);
         r_busy        <= (w_state_nxt != ST_IDLE);
         r_timeout_err <= w_timeout;
      end
   end

   // Registered GMII byte mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gmii_tx_en <= 1'b0;
         r_gmii_txd   <= 8'd0;
      end else if (r_mux_valid) begin
         r_gmii_tx_en <= port_tx_en[r_grant_id];
         r_gmii_txd   <= port_txd[{r_grant_id, 3'b000} +: 8];
      end else begin
         r_gmii_tx_en <= 1'b0;
         r_gmii_txd   <= 8'd0;
      end
   end

   assign port_sel    = r_port_sel;
   assign grant_id    = r_grant_id;
   assign gmii_tx_en  = r_gmii_tx_en;
   assign gmii_txd    = r_gmii_txd;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: vector table plus directed sequences
// for streaming, reset mid-frame, watchdog and pure round-robin wrap.
module tb_eth_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  port_req, port_done, port_tx_en, port_sel;
   logic [31:0] port_txd;
   logic        gmii_tx_en;
   logic [7:0]  gmii_txd;
   logic [1:0]  grant_id;
   logic        busy, timeout_err;

   logic [3:0]  rr_req, rr_done, rr_sel;
   logic        rr_en, rr_busy, rr_to;
   logic [7:0]  rr_txd;
   logic [1:0]  rr_gid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   eth_tx_arbiter #(.NUM_PORTS(4), .IFG_CYCLES(12), .PRIO_PORT0(1), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .port_req(port_req), .port_done(port_done), .port_sel(port_sel),
      .port_tx_en(port_tx_en), .port_txd(port_txd), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));

   eth_tx_arbiter #(.NUM_PORTS(4), .IFG_CYCLES(12), .PRIO_PORT0(0), .TIMEOUT_CYCLES(100)) dut_rr (
      .clk(clk), .rst(rst), .port_req(rr_req), .port_done(rr_done), .port_sel(rr_sel),
      .port_tx_en(4'b0000), .port_txd(32'h0000_0000), .gmii_tx_en(rr_en), .gmii_txd(rr_txd),
      .grant_id(rr_gid), .busy(rr_busy), .timeout_err(rr_to));

   typedef struct {
      string       name;
      logic [3:0]  req;
      logic [3:0]  done;
      logic [3:0]  tx_en;
      logic [31:0] txd;
      int          cycles;
      logic [3:0]  sel;
      logic [1:0]  gid;
      logic        busy;
      logic        en;
      logic [7:0]  txo;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      port_req = 4'b0; port_done = 4'b0; port_tx_en = 4'b0; port_txd = 32'h0;
      rr_req = 4'b0; rr_done = 4'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      for (int k = 0; k < 4; k++) if (v[k]) return k;
      return -1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cnt[4];
      int         q_gr[$];
      int         gaps[$];
      int         idle_run;
      int         data_err;
      int         ngr;
      bit         seen_burst;
      bit         inj_chk;
      logic       prev_en;
      logic [7:0] prev_byte;
      logic [3:0] prev_sel;
      int         exp_gr[4];

      // name, req, done, tx_en, txd, cycles -> sel, gid, busy, gmii_tx_en, gmii_txd
      vecs[0]  = '{"prio0_grant",    4'b0101, 4'b0000, 4'b0000, 32'h0000_0000,  1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h00};
      vecs[1]  = '{"p0_byte",        4'b0101, 4'b0000, 4'b0001, 32'h0000_00A5,  1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA5};
      vecs[2]  = '{"p0_done_tail",   4'b0100, 4'b0001, 4'b0001, 32'h0000_00A6,  1, 4'b0000, 2'd0, 1'b1, 1'b1, 8'hA6};
      vecs[3]  = '{"ifg_hold",       4'b0100, 4'b0000, 4'b0000, 32'h0000_0000, 11, 4'b0000, 2'd0, 1'b1, 1'b0, 8'h00};
      vecs[4]  = '{"ifg_end",        4'b0100, 4'b0000, 4'b0000, 32'h0000_0000,  1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{"p2_grant",       4'b0100, 4'b0000, 4'b0000, 32'h0000_0000,  1, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h00};
      vecs[6]  = '{"nonowner_done",  4'b0100, 4'b1000, 4'b0100, 32'h003C_0000,  1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h3C};
      vecs[7]  = '{"p2_done",        4'b0000, 4'b0100, 4'b0000, 32'h0000_0000,  1, 4'b0000, 2'd2, 1'b1, 1'b0, 8'h00};
      vecs[8]  = '{"ifg_req_held",   4'b0010, 4'b0000, 4'b0000, 32'h0000_0000, 11, 4'b0000, 2'd2, 1'b1, 1'b0, 8'h00};
      vecs[9]  = '{"ifg_to_idle",    4'b0010, 4'b0000, 4'b0000, 32'h0000_0000,  1, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00};
      vecs[10] = '{"p1_grant_rr",    4'b0010, 4'b0000, 4'b0000, 32'h0000_0000,  1, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h00};

      port_req = 4'b0; port_done = 4'b0; port_tx_en = 4'b0; port_txd = 32'h0;
      rr_req = 4'b0; rr_done = 4'b0;
      rst = 1'b1;
      tick(2);
      check("reset_state", {port_sel, grant_id, busy, gmii_tx_en, gmii_txd, timeout_err}, 17'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         port_req = vecs[i].req; port_done = vecs[i].done;
         port_tx_en = vecs[i].tx_en; port_txd = vecs[i].txd;
         tick(vecs[i].cycles);
         check(vecs[i].name, {port_sel, grant_id, busy, gmii_tx_en, gmii_txd, timeout_err},
               {vecs[i].sel, vecs[i].gid, vecs[i].busy, vecs[i].en, vecs[i].txo, 1'b0});
      end

      // Port 1 owns the bus; reset mid-frame, then port 3 re-requests.
      port_tx_en = 4'b0010; port_txd = 32'h0000_5500;
      tick(1);
      check("p1_stream", {gmii_tx_en, gmii_txd}, {1'b1, 8'h55});
      port_req = 4'b1000;
      #3 rst = 1'b1;
      #1 check("rst_async", {port_sel, busy, gmii_tx_en, gmii_txd}, 14'd0);
      port_tx_en = 4'b0; port_txd = 32'h0;
      #1 rst = 1'b0;
      tick(1);
      check("rst_regrant", {port_sel, grant_id}, {4'b1000, 2'd3});

      // Ports 1..3 stream 60-byte frames continuously.
      do_reset();
      port_req = 4'b1110;
      prev_en = 1'b0; prev_byte = 8'h00; prev_sel = 4'b0;
      idle_run = 0; seen_burst = 1'b0; data_err = 0; inj_chk = 1'b0;
      cnt = '{default: 0};
      for (int cyc = 0; cyc < 1000 && (q_gr.size() < 4 || gaps.size() < 3); cyc++) begin
         if (gmii_tx_en !== prev_en || (prev_en && gmii_txd !== prev_byte)) data_err++;
         if (timeout_err !== 1'b0) data_err++;
         if (inj_chk) begin
            check("nonowner_done_ignored", port_sel, 4'b0010);
            inj_chk = 1'b0;
         end
         if (gmii_tx_en) begin
            if (seen_burst && idle_run > 0) gaps.push_back(idle_run);
            seen_burst = 1'b1;
            idle_run = 0;
         end else begin
            idle_run++;
         end
         if (port_sel != 4'b0 && prev_sel == 4'b0) q_gr.push_back(onehot_idx(port_sel));
         prev_sel = port_sel;
         port_tx_en = 4'b0; port_txd = 32'h0; port_done = 4'b0;
         for (int p = 0; p < 4; p++) begin
            if (port_sel[p]) begin
               port_tx_en[p] = 1'b1;
               port_txd[8*p +: 8] = 8'(p * 64 + cnt[p]);
               if (cnt[p] == 59) begin
                  port_done[p] = 1'b1;
                  cnt[p] = 0;
               end else begin
                  cnt[p]++;
               end
            end
         end
         if (port_sel == 4'b0010 && cnt[1] == 30 && q_gr.size() == 1) begin
            port_done[3] = 1'b1;
            inj_chk = 1'b1;
         end
         prev_en = |port_tx_en;
         prev_byte = port_txd[7:0] | port_txd[15:8] | port_txd[23:16] | port_txd[31:24];
         tick(1);
      end
      exp_gr = '{1, 2, 3, 1};
      for (int i = 0; i < 4; i++)
         check("stream_grant_order", (q_gr.size() > i) ? q_gr[i] : -1, exp_gr[i]);
      check("stream_gap_count", gaps.size(), 3);
      for (int i = 0; i < gaps.size() && i < 3; i++)
         check("stream_gap_min12", (gaps[i] >= 12) ? 1 : 0, 1);
      check("stream_data", data_err, 0);

      // Owner never signals done.
      do_reset();
      port_req = 4'b0100;
      tick(1);
      check("to_grant", {port_sel, grant_id}, {4'b0100, 2'd2});
      port_req = 4'b0110;
`ifdef ETH_ARB_TIMEOUT_EN
      tick(99);
      check("to_hold", {port_sel, timeout_err}, {4'b0100, 1'b0});
      tick(1);
      check("to_release", {port_sel, timeout_err, busy}, {4'b0000, 1'b1, 1'b1});
      tick(1);
      check("to_pulse_once", timeout_err, 1'b0);
      tick(12);
      check("to_next_grant", {port_sel, grant_id}, {4'b0010, 2'd1});
`else
      tick(150);
      check("no_timeout_hold", {port_sel, timeout_err}, {4'b0100, 1'b0});
      port_done = 4'b0100;
      tick(1);
      port_done = 4'b0000;
      check("done_release", {port_sel, timeout_err}, {4'b0000, 1'b0});
`endif

      // Pure round-robin instance, all four ports requesting.
      do_reset();
      rr_req = 4'b1111;
      prev_sel = 4'b0;
      ngr = 0;
      for (int cyc = 0; cyc < 400 && ngr < 5; cyc++) begin
         rr_done = 4'b0;
         if (rr_sel != 4'b0 && prev_sel == 4'b0) begin
            check("rr_grant", {rr_sel, rr_gid}, {4'b0001 << (ngr % 4), 2'(ngr % 4)});
            ngr++;
            rr_done = rr_sel;
         end
         prev_sel = rr_sel;
         tick(1);
      end
      check("rr_grant_count", ngr, 5);
      rr_req = 4'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
